// File: rtl/cache_def.sv
// Shared cache types, plus the victim-cache arbiter's operation and state enums.
package cache_def;

    localparam int CACHE_ADDR_W = 32;
    localparam int CACHE_LINE_W = 128;

    typedef logic [CACHE_LINE_W-1:0] cache_data_type;

    typedef struct packed {
        logic                    valid;
        logic [CACHE_ADDR_W-1:0] addr;
    } cpu_req_type;

    typedef struct packed {
        logic                    valid;
        logic                    dirty;
        logic [CACHE_ADDR_W-1:0] addr;
        cache_data_type          data;
    } evict_data_type;

    typedef enum logic {
        LOOKUP = 1'b0,
        INSERT = 1'b1
    } vc_arb_op_e;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        CHECK = 2'd2,
        WRITE = 2'd3
    } vc_arb_state_e;

endpackage

// File: rtl/vc_arbiter_if.sv
// Requester, response, VC-port and statistics bundle between the L1 controllers and vc_arbiter.
interface vc_arbiter_if
    import cache_def::*;
#(
    parameter int ADDR_W = 32,
    parameter int LINE_W = 128
);
    logic              req0_valid;
    logic              req0_op;
    logic [ADDR_W-1:0] req0_addr;
    logic [LINE_W-1:0] req0_data;
    logic              req0_dirty;
    logic              req0_ready;

    logic              req1_valid;
    logic              req1_op;
    logic [ADDR_W-1:0] req1_addr;
    logic [LINE_W-1:0] req1_data;
    logic              req1_dirty;
    logic              req1_ready;

    logic              rsp0_valid;
    logic              rsp1_valid;
    logic              rsp_hit;
    logic              rsp_dirty;
    logic [LINE_W-1:0] rsp_data;

    cpu_req_type       vc_req;
    evict_data_type    vc_evict;
    evict_data_type    vc_res;

    logic [31:0]       grant0_cnt;
    logic [31:0]       grant1_cnt;
    logic [31:0]       conflict_cnt;

    modport slave (
        input  req0_valid, req0_op, req0_addr, req0_data, req0_dirty,
        input  req1_valid, req1_op, req1_addr, req1_data, req1_dirty,
        input  vc_res,
        output req0_ready, req1_ready,
        output rsp0_valid, rsp1_valid, rsp_hit, rsp_dirty, rsp_data,
        output vc_req, vc_evict,
        output grant0_cnt, grant1_cnt, conflict_cnt
    );

    modport master (
        output req0_valid, req0_op, req0_addr, req0_data, req0_dirty,
        output req1_valid, req1_op, req1_addr, req1_data, req1_dirty,
        output vc_res,
        input  req0_ready, req1_ready,
        input  rsp0_valid, rsp1_valid, rsp_hit, rsp_dirty, rsp_data,
        input  vc_req, vc_evict,
        input  grant0_cnt, grant1_cnt, conflict_cnt
    );

endinterface

// File: rtl/adder_32bit.sv
// 32-bit adder with carry-in; carry-out is dropped so counters wrap modulo 2^32.
module adder_32bit (
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        cin,
    output logic [31:0] sum
);
    assign sum = a + b + {31'd0, cin};
endmodule

// File: rtl/rr_arbiter_2.sv
// Two-way round-robin arbiter; on a conflict the requester that did not win last time is granted.
module rr_arbiter_2 (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic [1:0] req,
    input  logic       advance,
    output logic [1:0] gnt
);
    logic last_q;

    always_comb begin
        gnt = 2'b00;
        case (req)
            2'b01:   gnt = 2'b01;
            2'b10:   gnt = 2'b10;
            2'b11:   gnt = last_q ? 2'b01 : 2'b10;
            default: gnt = 2'b00;
        endcase
    end

    // Reset value 1 makes requester 0 win the first conflict.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            last_q <= 1'b1;
        end else if (advance && (|gnt)) begin
            last_q <= gnt[1];
        end
    end
endmodule

// File: rtl/vc_arbiter.sv
// Shares the victim-cache port between the L1 D-cache (req0) and I-cache (req1),
// sequencing lookups through ISSUE/CHECK and inserts through a single WRITE cycle.
module vc_arbiter
    import cache_def::*;
#(
    parameter int ADDR_W = 32,
    parameter int LINE_W = 128
) (
    input  logic         clk_i,
    input  logic         rst_i,
    vc_arbiter_if.slave  bus
);
    // state | meaning
    // IDLE  | grant a valid requester, latch its operation
    // ISSUE | first cycle of VC lookup (registered valid)
    // CHECK | lookup held; VC result sampled at this edge, response pulsed
    // WRITE | one-cycle VC insert, response pulsed with hit = 0
    vc_arb_state_e  state_q;
    logic           lat_id_q;
    cpu_req_type    vc_req_q;
    evict_data_type vc_evict_q;
    logic           rsp0_q, rsp1_q, hit_q, dirty_q;
    logic [LINE_W-1:0] data_q;

    logic [1:0]        req_v, gnt;
    logic              in_idle;
    logic              sel_op, sel_dirty;
    logic [ADDR_W-1:0] sel_addr;
    logic [LINE_W-1:0] sel_data;

    assign req_v   = {bus.req1_valid, bus.req0_valid};
    assign in_idle = (state_q == IDLE);

    rr_arbiter_2 u_rr (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .req     (req_v),
        .advance (in_idle),
        .gnt     (gnt)
    );

    assign bus.req0_ready = in_idle & gnt[0] & ~rst_i;
    assign bus.req1_ready = in_idle & gnt[1] & ~rst_i;

    assign sel_op    = gnt[1] ? bus.req1_op    : bus.req0_op;
    assign sel_addr  = gnt[1] ? bus.req1_addr  : bus.req0_addr;
    assign sel_data  = gnt[1] ? bus.req1_data  : bus.req0_data;
    assign sel_dirty = gnt[1] ? bus.req1_dirty : bus.req0_dirty;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= IDLE;
            lat_id_q   <= 1'b0;
            vc_req_q   <= '0;
            vc_evict_q <= '0;
            rsp0_q     <= 1'b0;
            rsp1_q     <= 1'b0;
            hit_q      <= 1'b0;
            dirty_q    <= 1'b0;
            data_q     <= '0;
        end else begin
            rsp0_q     <= 1'b0;
            rsp1_q     <= 1'b0;
            vc_evict_q <= '0;
            case (state_q)
                IDLE: begin
                    if (|gnt) begin
                        lat_id_q <= gnt[1];
                        if (vc_arb_op_e'(sel_op) == INSERT) begin
                            vc_evict_q <= '{valid: 1'b1, dirty: sel_dirty,
                                            addr: sel_addr, data: sel_data};
                            state_q    <= WRITE;
                        end else begin
                            vc_req_q <= '{valid: 1'b1, addr: sel_addr};
                            state_q  <= ISSUE;
                        end
                    end
                end
                ISSUE: state_q <= CHECK;
                CHECK: begin
                    vc_req_q <= '0;
                    hit_q    <= bus.vc_res.valid;
                    // Miss data is meaningless, so the previous line is kept.
                    if (bus.vc_res.valid) begin
                        dirty_q <= bus.vc_res.dirty;
                        data_q  <= bus.vc_res.data;
                    end
                    rsp0_q  <= ~lat_id_q;
                    rsp1_q  <= lat_id_q;
                    state_q <= IDLE;
                end
                WRITE: begin
                    hit_q   <= 1'b0;
                    rsp0_q  <= ~lat_id_q;
                    rsp1_q  <= lat_id_q;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.vc_req     = vc_req_q;
    assign bus.vc_evict   = vc_evict_q;
    assign bus.rsp0_valid = rsp0_q;
    assign bus.rsp1_valid = rsp1_q;
    assign bus.rsp_hit    = hit_q;
    assign bus.rsp_dirty  = dirty_q;
    assign bus.rsp_data   = data_q;

    logic [31:0] grant0_cnt_q, grant1_cnt_q, conflict_cnt_q;
    logic [31:0] grant0_nxt, grant1_nxt, conflict_nxt;

    adder_32bit u_add_g0 (.a(grant0_cnt_q),   .b(32'd0), .cin(1'b1), .sum(grant0_nxt));
    adder_32bit u_add_g1 (.a(grant1_cnt_q),   .b(32'd0), .cin(1'b1), .sum(grant1_nxt));
    adder_32bit u_add_cf (.a(conflict_cnt_q), .b(32'd0), .cin(1'b1), .sum(conflict_nxt));

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            grant0_cnt_q   <= '0;
            grant1_cnt_q   <= '0;
            conflict_cnt_q <= '0;
        end else begin
            if (in_idle && gnt[0]) grant0_cnt_q   <= grant0_nxt;
            if (in_idle && gnt[1]) grant1_cnt_q   <= grant1_nxt;
            if (in_idle && (&req_v)) conflict_cnt_q <= conflict_nxt;
        end
    end

    assign bus.grant0_cnt   = grant0_cnt_q;
    assign bus.grant1_cnt   = grant1_cnt_q;
    assign bus.conflict_cnt = conflict_cnt_q;
endmodule

// File: tb/tb_vc_arbiter.sv
// Directed bench for vc_arbiter: lookup hit/miss, insert, fairness, reset abort, counter wrap.
module tb_vc_arbiter;
    import cache_def::*;

    logic clk_i = 1'b0;
    logic rst_i = 1'b1;
    int   n_chk  = 0;
    int   n_pass = 0;

    always #5 clk_i = ~clk_i;

    vc_arbiter_if bus ();

    vc_arbiter dut (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .bus   (bus)
    );

    task automatic check(input string tag, input logic [191:0] act, input logic [191:0] exp);
        n_chk++;
        if (act !== exp)
            $display("FAIL %s: got %0h, expected %0h", tag, act, exp);
        else
            n_pass++;
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic idle_inputs();
        bus.req0_valid = 1'b0; bus.req0_op = 1'b0; bus.req0_addr = '0;
        bus.req0_data  = '0;   bus.req0_dirty = 1'b0;
        bus.req1_valid = 1'b0; bus.req1_op = 1'b0; bus.req1_addr = '0;
        bus.req1_data  = '0;   bus.req1_dirty = 1'b0;
        bus.vc_res     = '0;
    endtask

    cpu_req_type    exp_req;
    evict_data_type exp_ev;
    cache_data_type pat_a5;

    initial begin
        pat_a5 = {16{8'hA5}};
        idle_inputs();

        // Reset state
        tick(); tick();
        rst_i = 1'b0;
        #1;
        check("rst_ready0",   192'(bus.req0_ready), 192'(0));
        check("rst_ready1",   192'(bus.req1_ready), 192'(0));
        check("rst_rsp0",     192'(bus.rsp0_valid), 192'(0));
        check("rst_vc_req",   192'(bus.vc_req),     192'(0));
        check("rst_vc_evict", 192'(bus.vc_evict),   192'(0));
        check("rst_grant0",   192'(bus.grant0_cnt), 192'(0));
        check("rst_conflict", 192'(bus.conflict_cnt), 192'(0));

        // Single lookup hit from requester 0
        bus.req0_valid = 1'b1; bus.req0_op = 1'b0; bus.req0_addr = 32'h0000_1040;
        #1;
        check("hit_ready0", 192'(bus.req0_ready), 192'(1));
        check("hit_ready1", 192'(bus.req1_ready), 192'(0));
        tick();
        bus.req0_valid = 1'b0;
        exp_req = '{valid: 1'b1, addr: 32'h0000_1040};
        check("hit_issue_req", 192'(bus.vc_req), 192'(exp_req));
        bus.vc_res = '{valid: 1'b1, dirty: 1'b1, addr: 32'h0000_1040, data: pat_a5};
        tick();
        check("hit_check_req", 192'(bus.vc_req), 192'(exp_req));
        check("hit_check_rsp", 192'(bus.rsp0_valid), 192'(0));
        tick();
        bus.vc_res = '0;
        check("hit_rsp0",  192'(bus.rsp0_valid), 192'(1));
        check("hit_rsp1",  192'(bus.rsp1_valid), 192'(0));
        check("hit_hit",   192'(bus.rsp_hit),    192'(1));
        check("hit_dirty", 192'(bus.rsp_dirty),  192'(1));
        check("hit_data",  192'(bus.rsp_data),   192'(pat_a5));
        check("hit_req_off", 192'(bus.vc_req),   192'(0));
        tick();
        check("hit_pulse_end", 192'(bus.rsp0_valid), 192'(0));
        check("hit_hold",      192'(bus.rsp_hit),    192'(1));
        check("hit_grant0",    192'(bus.grant0_cnt), 192'(1));

        // Insert from requester 1
        bus.req1_valid = 1'b1; bus.req1_op = 1'b1; bus.req1_addr = 32'h0000_2080;
        bus.req1_data  = 128'h1234; bus.req1_dirty = 1'b0;
        #1;
        check("ins_ready1", 192'(bus.req1_ready), 192'(1));
        tick();
        bus.req1_valid = 1'b0;
        exp_ev = '{valid: 1'b1, dirty: 1'b0, addr: 32'h0000_2080, data: 128'h1234};
        check("ins_evict",   192'(bus.vc_evict), 192'(exp_ev));
        check("ins_no_req",  192'(bus.vc_req),   192'(0));
        tick();
        check("ins_evict_off", 192'(bus.vc_evict),   192'(0));
        check("ins_rsp1",      192'(bus.rsp1_valid), 192'(1));
        check("ins_rsp0",      192'(bus.rsp0_valid), 192'(0));
        check("ins_hit",       192'(bus.rsp_hit),    192'(0));
        check("ins_grant1",    192'(bus.grant1_cnt), 192'(1));
        tick();

        // Lookup miss
        bus.req0_valid = 1'b1; bus.req0_op = 1'b0; bus.req0_addr = 32'h0000_3000;
        tick();
        bus.req0_valid = 1'b0;
        bus.vc_res = '{valid: 1'b0, dirty: 1'b1, addr: 32'h0, data: {128{1'b1}}};
        tick(); tick();
        bus.vc_res = '0;
        check("miss_rsp0", 192'(bus.rsp0_valid), 192'(1));
        check("miss_hit",  192'(bus.rsp_hit),    192'(0));
        check("miss_data", 192'(bus.rsp_data),   192'(pat_a5));
        tick();

        // Conflict fairness from reset
        rst_i = 1'b1; tick(); rst_i = 1'b0;
        bus.req0_valid = 1'b1; bus.req0_op = 1'b0; bus.req0_addr = 32'h0000_0100;
        bus.req1_valid = 1'b1; bus.req1_op = 1'b0; bus.req1_addr = 32'h0000_0200;
        #1;
        for (int i = 0; i < 4; i++) begin
            check($sformatf("rr_ready0_%0d", i), 192'(bus.req0_ready), 192'((i % 2) == 0));
            check($sformatf("rr_ready1_%0d", i), 192'(bus.req1_ready), 192'((i % 2) == 1));
            tick();
            if (i == 3) begin
                bus.req0_valid = 1'b0;
                bus.req1_valid = 1'b0;
            end
            check($sformatf("rr_addr_%0d", i), 192'(bus.vc_req.addr),
                  192'(((i % 2) == 0) ? 32'h0000_0100 : 32'h0000_0200));
            tick(); tick();
            check($sformatf("rr_rsp0_%0d", i), 192'(bus.rsp0_valid), 192'((i % 2) == 0));
            check($sformatf("rr_rsp1_%0d", i), 192'(bus.rsp1_valid), 192'((i % 2) == 1));
        end
        check("rr_grant0",   192'(bus.grant0_cnt),   192'(2));
        check("rr_grant1",   192'(bus.grant1_cnt),   192'(2));
        check("rr_conflict", 192'(bus.conflict_cnt), 192'(4));

        // Reset during CHECK aborts the lookup; requester 0 wins the next conflict
        bus.req0_valid = 1'b1;
        tick();
        bus.req0_valid = 1'b0;
        tick();
        rst_i = 1'b1;
        bus.req0_valid = 1'b1; bus.req1_valid = 1'b1;
        tick();
        check("abort_rsp0",     192'(bus.rsp0_valid),   192'(0));
        check("abort_vc_req",   192'(bus.vc_req),       192'(0));
        check("abort_ready0",   192'(bus.req0_ready),   192'(0));
        check("abort_grant0",   192'(bus.grant0_cnt),   192'(0));
        check("abort_conflict", 192'(bus.conflict_cnt), 192'(0));
        rst_i = 1'b0;
        #1;
        check("abort_next_ready0", 192'(bus.req0_ready), 192'(1));
        check("abort_next_ready1", 192'(bus.req1_ready), 192'(0));
        tick();
        bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;
        check("abort_next_grant0", 192'(bus.grant0_cnt),   192'(1));
        check("abort_next_conf",   192'(bus.conflict_cnt), 192'(1));
        tick(); tick(); tick();

        // grant0 counter wrap
        force dut.grant0_cnt_q = 32'hFFFF_FFFF;
        #1;
        release dut.grant0_cnt_q;
        check("wrap_preload", 192'(bus.grant0_cnt), 192'(32'hFFFF_FFFF));
        bus.req0_valid = 1'b1; bus.req0_op = 1'b1; bus.req0_addr = 32'h0000_4000;
        tick();
        bus.req0_valid = 1'b0;
        check("wrap_grant0", 192'(bus.grant0_cnt), 192'(0));
        check("wrap_grant1", 192'(bus.grant1_cnt), 192'(0));
        tick();
        check("wrap_rsp0", 192'(bus.rsp0_valid), 192'(1));
        tick();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
